// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressed RISC-V data memory with REQ/READY handshake, wait states and fault checks
module data_memory_lsu #(
  parameter int Data_Mem_width  = 32,
  parameter int Data_Mem_length = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int WAIT_STATES     = 0
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  REQ,
  input  logic                  WE,
  input  logic [2:0]            SIZE,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [31:0]           WD,
  output logic [31:0]           RD,
  output logic                  READY,
  output logic                  BUSY,
  output logic                  FAULT
);
  localparam int IW = $clog2(Data_Mem_length);
  if (Data_Mem_width != 32) begin : g_bad_width
    $error("data_memory_lsu: Data_Mem_width must be 32");
  end
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t                state;
  logic                  we_q;
  logic [2:0]            size_q;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [31:0]           wd_q;
  logic [7:0]            cnt;
  logic [31:0]           mem [Data_Mem_length];
  logic                  idle, commit, s_we, fault_c;
  logic [2:0]            s_size;
  logic [ADDR_WIDTH-1:0] s_a;
  logic [31:0]           s_wd, word, ld, wdat;
  logic [IW-1:0]         idx;
  logic [7:0]            b;
  logic [15:0]           h;
  logic [3:0]            be;
  // With zero wait states the commit happens on the accept edge, so decode from the live inputs.
  assign idle   = state == S_IDLE;
  assign commit = idle ? REQ && WAIT_STATES == 0 : state == S_WAIT && cnt == 8'd0;
  assign s_we   = idle ? WE : we_q;
  assign s_size = idle ? SIZE : size_q;
  assign s_a    = idle ? A : a_q;
  assign s_wd   = idle ? WD : wd_q;
  assign idx    = s_a[IW+1:2];
  assign word   = mem[idx];
  always_comb begin
    fault_c = s_a >= ADDR_WIDTH'(4 * Data_Mem_length)
           || s_size inside {3'b011, 3'b110, 3'b111}
           || (s_we && s_size[2])
           || (s_size[1:0] == 2'b01 && s_a[0])
           || (s_size == 3'b010 && s_a[1:0] != 2'b00);
    b    = word[{s_a[1:0], 3'b000} +: 8];
    h    = s_a[1] ? word[31:16] : word[15:0];
    ld   = s_size[1:0] == 2'b00 ? {{24{~s_size[2] & b[7]}}, b}
         : s_size[1:0] == 2'b01 ? {{16{~s_size[2] & h[15]}}, h} : word;
    be   = s_size[1:0] == 2'b00 ? 4'b0001 << s_a[1:0]
         : s_size[1:0] == 2'b01 ? (s_a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdat = s_size[1:0] == 2'b00 ? {4{s_wd[7:0]}}
         : s_size[1:0] == 2'b01 ? {2{s_wd[15:0]}} : s_wd;
  end
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state  <= S_IDLE;
      we_q   <= 1'b0;
      size_q <= 3'b000;
      a_q    <= '0;
      wd_q   <= '0;
      cnt    <= 8'd0;
      RD     <= 32'd0;
      READY  <= 1'b0;
      BUSY   <= 1'b0;
      FAULT  <= 1'b0;
      for (int i = 0; i < Data_Mem_length; i++) mem[i] <= 32'd0;
    end else begin
      READY <= state == S_RESP;
      BUSY  <= (idle && REQ) || !idle;
      if (idle && REQ) begin
        we_q   <= WE;
        size_q <= SIZE;
        a_q    <= A;
        wd_q   <= WD;
        cnt    <= 8'(WAIT_STATES - 1);
        state  <= WAIT_STATES == 0 ? S_RESP : S_WAIT;
      end else if (state == S_WAIT) begin
        cnt   <= cnt - 8'd1;
        state <= cnt == 8'd0 ? S_RESP : S_WAIT;
      end else if (state == S_RESP) begin
        state <= S_IDLE;
      end
      if (commit) begin
        FAULT <= fault_c;
        RD    <= fault_c || s_we ? 32'd0 : ld;
        if (s_we && !fault_c)
          for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_data_memory_lsu.sv
// tb_data_memory_lsu: scoreboard bench driving a zero-wait and a three-wait instance
module tb_data_memory_lsu;
  typedef struct {logic [31:0] rd; logic f; int at;} exp_t;
  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        req [2];
  logic        we;
  logic [2:0]  size;
  logic [31:0] a, wd;
  logic [31:0] rdv [2];
  logic        rdy [2], busy [2], fl [2];
  exp_t        q [2][$];
  exp_t        e_m;
  int          pcyc = 0, checks = 0, errors = 0, k;
  always #5 clk = ~clk;
  always @(posedge clk) pcyc <= pcyc + 1;
  data_memory_lsu #(.WAIT_STATES(0)) u0 (
    .CLK(clk), .RST_n(rst_n[0]), .REQ(req[0]), .WE(we), .SIZE(size), .A(a), .WD(wd),
    .RD(rdv[0]), .READY(rdy[0]), .BUSY(busy[0]), .FAULT(fl[0]));
  data_memory_lsu #(.WAIT_STATES(3)) u3 (
    .CLK(clk), .RST_n(rst_n[1]), .REQ(req[1]), .WE(we), .SIZE(size), .A(a), .WD(wd),
    .RD(rdv[1]), .READY(rdy[1]), .BUSY(busy[1]), .FAULT(fl[1]));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    for (int d = 0; d < 2; d++) begin
      if (rdy[d]) begin
        if (q[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready dut%0d at %0d", d, pcyc);
        end else begin
          e_m = q[d].pop_front();
          chk($sformatf("rd_dut%0d", d), rdv[d], e_m.rd);
          chk($sformatf("fault_dut%0d", d), {31'd0, fl[d]}, {31'd0, e_m.f});
          chk($sformatf("latency_dut%0d", d), pcyc, e_m.at);
        end
      end else if (q[d].size() > 0 && pcyc > q[d][0].at) begin
        checks++;
        errors++;
        $display("FAIL timeout_dut%0d got no READY want READY by %0d", d, q[d][0].at);
        void'(q[d].pop_front());
      end
    end
  task automatic acc(input int d, input logic w, input logic [2:0] s, input logic [31:0] ad,
                     input logic [31:0] wdat, input logic [31:0] exp_rd, input logic ef);
    @(negedge clk);
    we = w; size = s; a = ad; wd = wdat; req[d] = 1'b1;
    q[d].push_back('{exp_rd, ef, pcyc + 2 + (d == 1 ? 3 : 0)});
    @(negedge clk);
    req[d] = 1'b0;
    repeat (d == 1 ? 5 : 2) @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n[0] = 1'b0; rst_n[1] = 1'b0; req[0] = 1'b0; req[1] = 1'b0;
    we = 1'b0; size = 3'b010; a = 32'd0; wd = 32'd0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_rd", rdv[d], 32'd0);
      chk("reset_ctl", {29'd0, rdy[d], busy[d], fl[d]}, 32'd0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    repeat (2) @(negedge clk);
    acc(0, 1, 3'b010, 4, 32'd22, 32'd0, 0);
    acc(0, 0, 3'b010, 4, 0, 32'd22, 0);
    acc(0, 1, 3'b000, 5, 32'h80, 32'd0, 0);
    acc(0, 0, 3'b000, 5, 0, 32'hFFFFFF80, 0);
    acc(0, 0, 3'b100, 5, 0, 32'h00000080, 0);
    acc(0, 0, 3'b010, 4, 0, 32'h00008016, 0);
    acc(0, 0, 3'b010, 6, 0, 32'd0, 1);
    acc(0, 1, 3'b001, 7, 32'hFFFF, 32'd0, 1);
    acc(0, 0, 3'b010, 4, 0, 32'h00008016, 0);
    acc(0, 0, 3'b011, 4, 0, 32'd0, 1);
    acc(0, 1, 3'b100, 4, 32'h55, 32'd0, 1);
    acc(0, 0, 3'b001, 4, 0, 32'hFFFF8016, 0);
    acc(0, 0, 3'b101, 6, 0, 32'd0, 0);
    acc(0, 1, 3'b001, 6, 32'h1234ABCD, 32'd0, 0);
    acc(0, 0, 3'b010, 4, 0, 32'hABCD8016, 0);
    acc(0, 0, 3'b001, 6, 0, 32'hFFFFABCD, 0);
    acc(0, 1, 3'b010, 256, 32'd1, 32'd0, 1);
    acc(0, 0, 3'b010, 0, 0, 32'd0, 0);
    acc(0, 1, 3'b010, 252, 32'hCAFEF00D, 32'd0, 0);
    acc(0, 0, 3'b010, 252, 0, 32'hCAFEF00D, 0);
    acc(1, 1, 3'b010, 0, 32'h1234, 32'd0, 0);
    @(negedge clk);
    we = 1'b0; size = 3'b010; a = 32'd0; req[1] = 1'b1;
    k = pcyc;
    q[1].push_back('{32'h1234, 1'b0, k + 5});
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      req[1] = (i == 2);
      chk($sformatf("busy_w3_c%0d", i), {31'd0, busy[1]}, {31'd0, i < 6});
    end
    @(negedge clk);
    we = 1'b1; size = 3'b010; a = 32'd8; wd = 32'hDEADBEEF; req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    chk("midreset_rd", rdv[1], 32'd0);
    chk("midreset_ctl", {29'd0, rdy[1], busy[1], fl[1]}, 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    repeat (2) @(negedge clk);
    acc(1, 0, 3'b010, 8, 0, 32'd0, 0);
    acc(1, 0, 3'b010, 0, 0, 32'd0, 0);
    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("drained_dut%0d", d), q[d].size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
